// File: rtl/card_pkg.sv
// card_pkg -- shared types and constants for the card vote filter.
//   card_map_t     : packed card identity, [5:4] suit, [3:0] rank
//   vote_state_e   : vote FSM states
//   RANK_MIN/MAX   : legal rank window (inclusive)
//   sample_valid() : per-frame acceptance test (scores and rank window)
package card_pkg;

    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } card_map_t;

    typedef enum logic [1:0] {
        StIdle,
        StCandidate,
        StLocked,
        StLosing
    } vote_state_e;

    localparam logic [3:0] RANK_MIN = 4'd1;
    localparam logic [3:0] RANK_MAX = 4'd13;

    // Unsigned 7-bit compares; rank must fall in RANK_MIN..RANK_MAX.
    function automatic logic sample_valid(
        input card_map_t  card,
        input logic [6:0] rank_score,
        input logic [6:0] suit_score,
        input logic [6:0] score_min
    );
        return (rank_score >= score_min) && (suit_score >= score_min) &&
               (card.rank >= RANK_MIN) && (card.rank <= RANK_MAX);
    endfunction

endpackage

// File: rtl/streak_counter.sv
// streak_counter -- saturating 4-bit counter with clear / load-1 / increment.
//   clk_in       : clock (clk_65mhz domain)
//   rst_in       : synchronous active-low reset
//   clr_in       : force count to 0 (highest priority)
//   load_one_in  : force count to 1
//   inc_in       : count + 1, holds at 15
//   count_out    : current count
module streak_counter (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       clr_in,
    input  logic       load_one_in,
    input  logic       inc_in,
    output logic [3:0] count_out
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_in) begin
            count_d = 4'd0;
        end else if (load_one_in) begin
            count_d = 4'd1;
        end else if (inc_in && (count_q != 4'hF)) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/card_vote_filter.sv
// card_vote_filter -- temporal vote over per-frame card_math results. A card
// locks after STABLE_FRAMES consecutive agreeing valid frames and drops after
// LOST_FRAMES consecutive non-matching frames; a challenger that reaches
// STABLE_FRAMES while losing takes over the lock directly.
//   clk_in          : clock (clk_65mhz domain)
//   rst_in          : synchronous active-low reset
//   frame_done_in   : one sample per cycle while high
//   card_map_in     : [5:4] suit, [3:0] rank
//   rank_score_in   : rank match score
//   suit_score_in   : suit match score
//   score_min_in    : minimum acceptable score
//   card_map_out    : locked card identity
//   rank_score_out  : rank score of last sample agreeing with the lock
//   suit_score_out  : suit score of last sample agreeing with the lock
//   stable_out      : high while a card is locked
//   change_out      : one-cycle pulse when card_map_out or stable_out changes
// Optional feature macro CARD_VOTE_HOLD_EN: on a drop, keep the last locked
// card and scores on the outputs (stable_out still falls).
module card_vote_filter
    import card_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 4,
    parameter int unsigned LOST_FRAMES   = 8
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       frame_done_in,
    input  logic [5:0] card_map_in,
    input  logic [6:0] rank_score_in,
    input  logic [6:0] suit_score_in,
    input  logic [6:0] score_min_in,
    output logic [5:0] card_map_out,
    output logic [6:0] rank_score_out,
    output logic [6:0] suit_score_out,
    output logic       stable_out,
    output logic       change_out
);

    // A counter at *_LAST means the current frame is the deciding one.
    localparam logic [3:0] STREAK_LAST = 4'(STABLE_FRAMES - 1);
    localparam logic [3:0] MISS_LAST   = 4'(LOST_FRAMES - 1);

    vote_state_e state_q, state_d;
    card_map_t   cand_q, cand_d;
    card_map_t   card_q, card_d;
    logic [6:0]  rank_q, rank_d;
    logic [6:0]  suit_q, suit_d;
    logic        stable_q, stable_d;
    logic        change_q, change_d;

    logic        streak_clr, streak_load, streak_inc;
    logic        miss_clr, miss_load, miss_inc;
    logic [3:0]  streak_cnt;
    logic [3:0]  miss_cnt;

    card_map_t   sample;
    logic        valid;
    logic        same_cand;
    logic        match_lock;

    assign sample     = card_map_t'(card_map_in);
    assign valid      = frame_done_in &&
                        sample_valid(sample, rank_score_in, suit_score_in, score_min_in);
    // A cleared streak means no live challenger even if cand_q still holds a card.
    assign same_cand  = (sample == cand_q) && (streak_cnt != 4'd0);
    assign match_lock = valid && (sample == card_q);

    streak_counter u_streak (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .clr_in      (streak_clr),
        .load_one_in (streak_load),
        .inc_in      (streak_inc),
        .count_out   (streak_cnt)
    );

    streak_counter u_miss (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .clr_in      (miss_clr),
        .load_one_in (miss_load),
        .inc_in      (miss_inc),
        .count_out   (miss_cnt)
    );

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        card_d      = card_q;
        rank_d      = rank_q;
        suit_d      = suit_q;
        stable_d    = stable_q;
        streak_clr  = 1'b0;
        streak_load = 1'b0;
        streak_inc  = 1'b0;
        miss_clr    = 1'b0;
        miss_load   = 1'b0;
        miss_inc    = 1'b0;

        if (frame_done_in) begin
            unique case (state_q)
                StIdle: begin
                    if (valid) begin
                        cand_d      = sample;
                        streak_load = 1'b1;
                        state_d     = StCandidate;
                    end
                end
                StCandidate: begin
                    if (!valid) begin
                        streak_clr = 1'b1;
                        state_d    = StIdle;
                    end else if (sample == cand_q) begin
                        if (streak_cnt >= STREAK_LAST) begin
                            card_d     = sample;
                            rank_d     = rank_score_in;
                            suit_d     = suit_score_in;
                            stable_d   = 1'b1;
                            streak_clr = 1'b1;
                            miss_clr   = 1'b1;
                            state_d    = StLocked;
                        end else begin
                            streak_inc = 1'b1;
                        end
                    end else begin
                        cand_d      = sample;
                        streak_load = 1'b1;
                    end
                end
                StLocked: begin
                    if (match_lock) begin
                        rank_d = rank_score_in;
                        suit_d = suit_score_in;
                    end else begin
                        miss_load = 1'b1;
                        state_d   = StLosing;
                        if (valid) begin
                            cand_d      = sample;
                            streak_load = 1'b1;
                        end else begin
                            streak_clr = 1'b1;
                        end
                    end
                end
                StLosing: begin
                    if (match_lock) begin
                        rank_d     = rank_score_in;
                        suit_d     = suit_score_in;
                        miss_clr   = 1'b1;
                        streak_clr = 1'b1;
                        state_d    = StLocked;
                    end else if (valid && same_cand && (streak_cnt >= STREAK_LAST)) begin
                        // Challenger wins before the miss count is considered.
                        card_d     = sample;
                        rank_d     = rank_score_in;
                        suit_d     = suit_score_in;
                        miss_clr   = 1'b1;
                        streak_clr = 1'b1;
                        state_d    = StLocked;
                    end else if (miss_cnt >= MISS_LAST) begin
                        stable_d   = 1'b0;
                        miss_clr   = 1'b1;
                        streak_clr = 1'b1;
                        state_d    = StIdle;
`ifndef CARD_VOTE_HOLD_EN
                        card_d     = card_map_t'(6'd0);
                        rank_d     = 7'd0;
                        suit_d     = 7'd0;
`endif
                    end else begin
                        miss_inc = 1'b1;
                        if (!valid) begin
                            streak_clr = 1'b1;
                        end else if (same_cand) begin
                            streak_inc = 1'b1;
                        end else begin
                            cand_d      = sample;
                            streak_load = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Score-only refreshes leave both compared fields untouched.
        change_d = (card_d != card_q) || (stable_d != stable_q);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q  <= StIdle;
            cand_q   <= card_map_t'(6'd0);
            card_q   <= card_map_t'(6'd0);
            rank_q   <= 7'd0;
            suit_q   <= 7'd0;
            stable_q <= 1'b0;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            card_q   <= card_d;
            rank_q   <= rank_d;
            suit_q   <= suit_d;
            stable_q <= stable_d;
            change_q <= change_d;
        end
    end

    assign card_map_out   = card_q;
    assign rank_score_out = rank_q;
    assign suit_score_out = suit_q;
    assign stable_out     = stable_q;
    assign change_out     = change_q;

endmodule

// File: tb/tb_card_vote_filter.sv
// tb_card_vote_filter -- self-checking bench for card_vote_filter.
// Table-driven vectors, hand-written corner sequences and a randomized run,
// all compared against a behavioural model (lock flag + run/miss tallies).
// Honours CARD_VOTE_HOLD_EN for drop expectations.
module tb_card_vote_filter;

    localparam int unsigned STABLE = 4;
    localparam int unsigned LOST   = 8;
    localparam logic [6:0]  SMIN   = 7'd40;

`ifdef CARD_VOTE_HOLD_EN
    localparam logic [5:0] DropCard1A = 6'h1A;
    localparam logic [5:0] DropCard25 = 6'h25;
`else
    localparam logic [5:0] DropCard1A = 6'h00;
    localparam logic [5:0] DropCard25 = 6'h00;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_done = 1'b0;
    logic [5:0] card_map = 6'd0;
    logic [6:0] rank_score = 7'd0;
    logic [6:0] suit_score = 7'd0;
    logic [6:0] score_min = SMIN;
    logic [5:0] card_map_out;
    logic [6:0] rank_score_out;
    logic [6:0] suit_score_out;
    logic       stable_out;
    logic       change_out;

    always #5 clk = ~clk;

    card_vote_filter #(
        .STABLE_FRAMES (STABLE),
        .LOST_FRAMES   (LOST)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .frame_done_in  (frame_done),
        .card_map_in    (card_map),
        .rank_score_in  (rank_score),
        .suit_score_in  (suit_score),
        .score_min_in   (score_min),
        .card_map_out   (card_map_out),
        .rank_score_out (rank_score_out),
        .suit_score_out (suit_score_out),
        .stable_out     (stable_out),
        .change_out     (change_out)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Behavioural model: "locked" flag, consecutive-agreement run for the
    // current candidate/challenger, consecutive miss tally while locked.
    bit         m_locked;
    logic [5:0] m_cand;
    int         m_run;
    int         m_miss;
    logic [5:0] o_card;
    logic [6:0] o_rs;
    logic [6:0] o_ss;
    logic       o_stable;
    logic       o_change;

    task automatic model_reset();
        m_locked = 0;
        m_cand   = 6'd0;
        m_run    = 0;
        m_miss   = 0;
        o_card   = 6'd0;
        o_rs     = 7'd0;
        o_ss     = 7'd0;
        o_stable = 1'b0;
        o_change = 1'b0;
    endtask

    task automatic take_lock(input logic [5:0] c, input logic [6:0] r, input logic [6:0] s);
        m_locked = 1;
        o_card   = c;
        o_rs     = r;
        o_ss     = s;
        o_stable = 1'b1;
        m_run    = 0;
        m_miss   = 0;
    endtask

    // Extend (or restart) the agreement run with a valid sample.
    task automatic vote(input logic [5:0] c);
        if (m_run > 0 && c == m_cand) begin
            m_run++;
        end else begin
            m_cand = c;
            m_run  = 1;
        end
    endtask

    task automatic model_step(input bit fd, input logic [5:0] c,
                              input logic [6:0] r, input logic [6:0] s);
        logic [5:0] p_card;
        logic       p_stable;
        bit         ok;
        p_card   = o_card;
        p_stable = o_stable;
        if (fd) begin
            ok = (r >= score_min) && (s >= score_min) &&
                 (int'(c[3:0]) >= 1) && (int'(c[3:0]) <= 13);
            if (!m_locked) begin
                if (ok) begin
                    vote(c);
                    if (m_run >= int'(STABLE)) take_lock(c, r, s);
                end else begin
                    m_run = 0;
                end
            end else if (ok && c == o_card) begin
                m_miss = 0;
                m_run  = 0;
                o_rs   = r;
                o_ss   = s;
            end else begin
                m_miss++;
                if (ok) vote(c);
                else m_run = 0;
                if (ok && m_run >= int'(STABLE)) begin
                    take_lock(c, r, s);
                end else if (m_miss >= int'(LOST)) begin
                    m_locked = 0;
                    m_miss   = 0;
                    m_run    = 0;
                    o_stable = 1'b0;
`ifndef CARD_VOTE_HOLD_EN
                    o_card   = 6'd0;
                    o_rs     = 7'd0;
                    o_ss     = 7'd0;
`endif
                end
            end
        end
        o_change = (o_card != p_card) || (o_stable != p_stable);
    endtask

    task automatic check_model();
        check("card_map_out", card_map_out, o_card);
        check("rank_score_out", rank_score_out, o_rs);
        check("suit_score_out", suit_score_out, o_ss);
        check("stable_out", stable_out, o_stable);
        check("change_out", change_out, o_change);
    endtask

    task automatic step(input bit fd, input logic [5:0] c,
                        input logic [6:0] r, input logic [6:0] s);
        @(negedge clk);
        rst_n      = 1'b1;
        frame_done = fd;
        card_map   = c;
        rank_score = r;
        suit_score = s;
        @(posedge clk);
        model_step(fd, c, r, s);
        #1;
        check_model();
    endtask

    // Valid-looking frame applied during reset must be ignored.
    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        frame_done = 1'b1;
        card_map   = 6'h25;
        rank_score = 7'd60;
        suit_score = 7'd55;
        @(posedge clk);
        model_reset();
        #1;
        check_model();
    endtask

    typedef struct {
        bit         fd;
        logic [5:0] card;
        logic [6:0] rs;
        logic [6:0] ss;
        logic [5:0] e_card;
        bit         e_stable;
        bit         e_change;
    } vec_t;

    vec_t vecs[$];

    int n_change;
    bit seen;

    initial begin
        // Lock, score refresh, single miss + recovery, challenger takeover, drop.
        for (int i = 0; i < 3; i++) vecs.push_back('{1, 6'h25, 7'd60, 7'd55, 6'h00, 0, 0});
        vecs.push_back('{1, 6'h25, 7'd60, 7'd55, 6'h25, 1, 1});
        vecs.push_back('{0, 6'h25, 7'd60, 7'd55, 6'h25, 1, 0});
        vecs.push_back('{1, 6'h25, 7'd39, 7'd55, 6'h25, 1, 0});
        vecs.push_back('{1, 6'h25, 7'd61, 7'd56, 6'h25, 1, 0});
        for (int i = 0; i < 3; i++) vecs.push_back('{1, 6'h1A, 7'd70, 7'd70, 6'h25, 1, 0});
        vecs.push_back('{1, 6'h1A, 7'd70, 7'd70, 6'h1A, 1, 1});
        for (int i = 0; i < 7; i++) vecs.push_back('{1, 6'h0E, 7'd100, 7'd100, 6'h1A, 1, 0});
        vecs.push_back('{1, 6'h0E, 7'd100, 7'd100, DropCard1A, 0, 1});
        vecs.push_back('{0, 6'h00, 7'd0, 7'd0, DropCard1A, 0, 0});

        model_reset();
        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].fd, vecs[i].card, vecs[i].rs, vecs[i].ss);
            check($sformatf("vec%0d_card", i), card_map_out, vecs[i].e_card);
            check($sformatf("vec%0d_stable", i), stable_out, vecs[i].e_stable);
            check($sformatf("vec%0d_change", i), change_out, vecs[i].e_change);
        end

        // Interrupted streak never locks.
        do_reset();
        seen = 0;
        for (int i = 0; i < 3; i++) begin step(1, 6'h25, 60, 55); seen |= change_out; end
        step(1, 6'h25, 39, 55);
        seen |= change_out;
        for (int i = 0; i < 3; i++) begin step(1, 6'h25, 60, 55); seen |= change_out; end
        check("interrupt_stable", stable_out, 0);
        check("interrupt_no_change", seen, 0);

        // Five misses then recovery, then eight misses drop.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 6'h25, 60, 55);
        check("miss_locked", stable_out, 1);
        n_change = 0;
        for (int i = 0; i < 5; i++) begin step(1, 6'h25, 39, 55); n_change += change_out; end
        step(1, 6'h25, 60, 55);
        n_change += change_out;
        check("miss5_stable", stable_out, 1);
        check("miss5_card", card_map_out, 6'h25);
        check("miss5_changes", n_change, 0);
        for (int i = 0; i < 7; i++) step(1, 6'h25, 39, 55);
        check("miss7_stable", stable_out, 1);
        step(1, 6'h25, 39, 55);
        check("drop_stable", stable_out, 0);
        check("drop_change", change_out, 1);
        check("drop_card", card_map_out, DropCard25);

        // Out-of-window ranks with perfect scores are never valid.
        do_reset();
        seen = 0;
        for (int i = 0; i < 6; i++) begin step(1, 6'h20, 100, 100); seen |= stable_out; end
        for (int i = 0; i < 6; i++) begin step(1, 6'h2E, 100, 100); seen |= stable_out; end
        check("bad_rank_never_locks", seen, 0);

        // Reset mid-lock, then relock.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 6'h25, 60, 55);
        check("prereset_stable", stable_out, 1);
        do_reset();
        check("reset_stable", stable_out, 0);
        check("reset_change", change_out, 0);
        check("reset_card", card_map_out, 0);
        n_change = 0;
        for (int i = 0; i < 4; i++) begin step(1, 6'h25, 60, 55); n_change += change_out; end
        check("relock_stable", stable_out, 1);
        check("relock_card", card_map_out, 6'h25);
        check("relock_changes", n_change, 1);

        // Randomized run: sticky card choice so streaks, takeovers and drops occur.
        do_reset();
        begin
            logic [5:0] pool [5];
            logic [5:0] cur;
            pool[0] = 6'h25; pool[1] = 6'h1A; pool[2] = 6'h13;
            pool[3] = 6'h20; pool[4] = 6'h3E;
            cur = pool[0];
            for (int i = 0; i < 2500; i++) begin
                if ($urandom_range(0, 499) == 0) begin
                    do_reset();
                end else begin
                    if ($urandom_range(0, 99) < 20) cur = pool[$urandom_range(0, 4)];
                    step($urandom_range(0, 99) < 80, cur,
                         7'($urandom_range(30, 100)), 7'($urandom_range(30, 100)));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/card_vote_filter.md
CARD_VOTE_FILTER -- requirements
Module: card_vote_filter

Interface
REQ-001 SHALL have parameter STABLE_FRAMES, default 4, meaning consecutive agreeing frames needed to lock a card (legal range 2..15).
REQ-002 SHALL have parameter LOST_FRAMES, default 8, meaning consecutive non-matching frames before a lock is dropped (legal range 2..15).
REQ-003 SHALL have port clk_in  input  1  system clock (clk_65mhz domain).
REQ-004 SHALL have port rst_in  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port frame_done_in  input  1  single-cycle pulse; per-frame card_math result valid this cycle.
REQ-006 SHALL have port card_map_in  input  6  [5:4] suit, [3:0] rank from card_math.
REQ-007 SHALL have ports rank_score_in and suit_score_in  input  7 each  match scores from card_math.
REQ-008 SHALL have port score_min_in  input  7  minimum acceptable score, unsigned.
REQ-009 SHALL have port card_map_out  output  6  locked card identity for seven_segment_controller.
REQ-010 SHALL have ports rank_score_out and suit_score_out  output  7 each  scores of the last sample agreeing with the lock.
REQ-011 SHALL have port stable_out  output  1  high while a card is locked.
REQ-012 SHALL have port change_out  output  1  one-cycle pulse whenever card_map_out or stable_out changes.

Function
REQ-013 A sample (taken only when frame_done_in=1) SHALL be valid iff rank_score_in>=score_min_in, suit_score_in>=score_min_in and rank in 1..13; all compares unsigned 7-bit.
REQ-014 The FSM SHALL have states IDLE, CANDIDATE, LOCKED, LOSING; transitions only on cycles with frame_done_in=1.
REQ-015 IDLE: valid sample -> store candidate, streak=1, go CANDIDATE; invalid -> stay.
REQ-016 CANDIDATE: valid equal to candidate -> streak+1, on reaching STABLE_FRAMES go LOCKED; valid different -> replace candidate, streak=1; invalid -> IDLE, streak=0.
REQ-017 LOCKED: valid equal to locked card -> stay, refresh score outputs; any other sample -> miss=1, go LOSING; a valid different sample also starts challenger streak=1.
REQ-018 LOSING: valid equal to locked -> LOCKED, miss=0, challenger cleared; otherwise miss+1, and a valid non-locked sample advances (same challenger) or restarts (new challenger) the challenger streak; an invalid sample clears the challenger streak.
REQ-019 LOSING: challenger streak reaching STABLE_FRAMES SHALL take priority over miss: lock challenger directly, go LOCKED, miss=0.
REQ-020 LOSING: miss reaching LOST_FRAMES (no challenger lock) -> IDLE, stable_out=0.
REQ-021 All outputs SHALL be registered; they update the cycle after the deciding frame_done_in (latency 1).
REQ-022 change_out SHALL pulse exactly one cycle, coincident with the output update, on lock, relock-to-challenger, and drop; never on a score-only refresh.
REQ-023 Streak and miss counters SHALL saturate and never wrap; frame_done_in held high for consecutive cycles SHALL count as one sample per cycle.

Reset
REQ-024 rst_in=0 at a clock edge SHALL force state IDLE, all counters 0, card_map_out=0, score outputs 0, stable_out=0, change_out=0; frame_done_in ignored while in reset.
REQ-025 Reset mid-lock SHALL not produce a change_out pulse.

Configuration
REQ-026 Macro CARD_VOTE_HOLD_EN: when defined, a drop (REQ-020) SHALL keep card_map_out and score outputs at the last locked values with stable_out=0; when undefined, a drop SHALL clear them to 0.

Structure
REQ-027 Shared package card_pkg SHALL hold the card_map typedef (suit 2b, rank 4b), the FSM state enum, and constants RANK_MIN=1, RANK_MAX=13.
REQ-028 Sub-module streak_counter (saturating 4-bit, clear/increment/load-1) SHALL be instantiated for the candidate/challenger streak and for the miss count.

Verification (STABLE_FRAMES=4, LOST_FRAMES=8, score_min_in=40)
REQ-029 4 frames card_map 6'h25 scores 60/55 -> stable_out=1, card_map_out=6'h25, one change_out pulse, one cycle after the 4th frame_done_in.
REQ-030 3 frames 6'h25 then one with rank_score=39 then 3 frames 6'h25 -> stable_out stays 0, no change_out.
REQ-031 Locked 6'h25, 5 invalid frames then 6'h25 -> stays locked, no change_out; 8 invalid frames -> stable_out=0, change_out pulse, card_map_out=0 (or 6'h25 with CARD_VOTE_HOLD_EN).
REQ-032 Locked 6'h25, 4 frames 6'h1A -> card_map_out=6'h1A after 4th, stable_out stays 1, exactly one change_out.
REQ-033 Rank 0 or 14 with scores 100 -> never valid, never locks.
REQ-034 Locked, rst_in=0 one cycle -> all outputs 0 next cycle, no change_out; 4 valid frames relock normally.
